// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arb_pkg : shared types and constants for the 3-way bus arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int NUM_REQ = 3;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_R0   = 3'b001;
  localparam logic [2:0] SEL_R1   = 3'b010;
  localparam logic [2:0] SEL_R2   = 3'b100;

  // Round-robin pointer to load after the given one-hot owner releases.
  function automatic logic [1:0] next_ptr(input logic [2:0] owner);
    case (owner)
      SEL_R0:  return 2'd1;
      SEL_R1:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick3 : combinational 3-way round-robin picker (one-hot winner + valid)
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_pick3
  import bus_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic       valid
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so the pointed-to requester sits in bit 0, pick lowest, rotate back.
  always_comb begin
    rot  = req;
    pick = SEL_NONE;
    win  = SEL_NONE;
    case (ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;
    else             pick = 3'b000;
    case (ptr)
      2'd1:    win = {pick[1], pick[0], pick[2]};
      2'd2:    win = {pick[0], pick[2], pick[1]};
      default: win = pick;
    endcase
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_rr_arbiter3 : 3-requester round-robin bus arbiter with dead cycle and watchdog
// Revision        : 1.0
// ---------------------------------------------------------------------------
module bus_rr_arbiter3
  import bus_arb_pkg::*;
#(
  parameter int TO_CYCLES = 1024,
  parameter int TO_W      = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       finish,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic [2:0] sel,
  output logic       busy,
  output logic       to_err,
  output logic [2:0] to_sel
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [TO_W-1:0] wd_cnt;
  logic [2:0]      pick_win;
  logic            pick_valid;
  logic            wd_expire;

  rr_pick3 u_pick (
    .req   ({req2, req1, req0}),
    .ptr   (rr_ptr),
    .win   (pick_win),
    .valid (pick_valid)
  );

  assign wd_expire = (TO_CYCLES != 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= SEL_NONE;
      busy   <= 1'b0;
      to_err <= 1'b0;
      to_sel <= SEL_NONE;
      rr_ptr <= 2'd0;
      wd_cnt <= '0;
    end else begin
      to_err <= 1'b0;
      case (state)
        GRANT: begin
          if (finish || wd_expire) begin
            state  <= RELEASE;
            sel    <= SEL_NONE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr(sel);
            wd_cnt <= '0;
            // A finish arriving on the expiry cycle is a normal completion.
            if (!finish) begin
              to_err <= 1'b1;
              to_sel <= sel;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          if (pick_valid) begin
            state  <= GRANT;
            sel    <= pick_win;
            busy   <= 1'b1;
            wd_cnt <= '0;
          end else begin
            state  <= IDLE;
            sel    <= SEL_NONE;
            busy   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt0 = sel[0];
  assign gnt1 = sel[1];
  assign gnt2 = sel[2];

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter3 : directed + random check of bus_rr_arbiter3 against a reference model
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter3;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, finish = 1'b0;
  logic       gnt0, gnt1, gnt2, busy, to_err;
  logic [2:0] sel, to_sel;

  int n_cmp = 0;
  int n_bad = 0;

  bus_rr_arbiter3 #(.TO_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .req2(req2),
    .finish(finish), .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .sel(sel),
    .busy(busy), .to_err(to_err), .to_sel(to_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), pointer, cycles held so far.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic       m_err   = 1'b0;
  logic [2:0] m_tosel = 3'b000;

  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] r;
    logic [2:0] m_sel;
    int j;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_err = 1'b0; m_tosel = 3'b000;
    end else begin
      r = {req2, req1, req0};
      m_err = 1'b0;
      if (m_owner >= 0) begin
        if (finish) begin
          m_ptr = (m_owner + 1) % 3;
          m_owner = -1;
        end else if (m_held == TO - 1) begin
          m_err = 1'b1;
          m_tosel = 3'(1 << m_owner);
          m_ptr = (m_owner + 1) % 3;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          j = (m_ptr + k) % 3;
          if (m_owner < 0 && r[j]) begin
            m_owner = j;
            m_held = 0;
          end
        end
      end
    end
    #1;
    m_sel = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    chk("gnt",    {29'd0, gnt2, gnt1, gnt0}, {29'd0, m_sel});
    chk("sel",    {29'd0, sel},    {29'd0, m_sel});
    chk("busy",   {31'd0, busy},   {31'd0, |m_sel});
    chk("to_err", {31'd0, to_err}, {31'd0, m_err});
    chk("to_sel", {29'd0, to_sel}, {29'd0, m_tosel});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [2:0] e);
    chk(name, {28'd0, busy, sel}, {28'd0, |e, e});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; finish = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    cyc();
    finish = 1'b0;
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    lit("reset", 3'b000);
    chk("reset_to_sel", {29'd0, to_sel}, 32'd0);

    // Rotation with all three requesting.
    req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
    cyc();              lit("t1_g0", 3'b001);
    repeat (3) cyc();
    pulse_finish();     lit("t1_rel0", 3'b000);
    cyc();              lit("t1_g1", 3'b010);
    pulse_finish();     lit("t1_rel1", 3'b000);
    cyc();              lit("t1_g2", 3'b100);
    pulse_finish();
    cyc();              lit("t1_wrap", 3'b001);

    // Owner drops request; grant held, no preemption.
    do_reset();
    req1 = 1'b1;
    cyc();              lit("t2_g1", 3'b010);
    cyc();
    req1 = 1'b0;
    cyc();              lit("t2_hold", 3'b010);
    req0 = 1'b1;
    cyc(); cyc();       lit("t2_nopre", 3'b010);
    pulse_finish();     lit("t2_rel", 3'b000);
    cyc();              lit("t2_g0", 3'b001);
    req0 = 1'b0;
    pulse_finish();
    cyc();

    // Watchdog expiry.
    do_reset();
    req2 = 1'b1;
    cyc();              lit("t4_g2", 3'b100);
    repeat (14) cyc();
    req0 = 1'b1;
    cyc();              lit("t4_c16", 3'b100);
    chk("t4_noerr", {31'd0, to_err}, 32'd0);
    cyc();              lit("t4_drop", 3'b000);
    chk("t4_err", {31'd0, to_err}, 32'd1);
    chk("t4_tosel", {29'd0, to_sel}, 32'd4);
    cyc();              lit("t4_g0", 3'b001);
    chk("t4_errpulse", {31'd0, to_err}, 32'd0);
    chk("t4_tohold", {29'd0, to_sel}, 32'd4);
    req0 = 1'b0; req2 = 1'b0;
    pulse_finish();
    cyc();

    // Spurious finish in idle.
    do_reset();
    pulse_finish();     lit("t3_idle", 3'b000);
    cyc();              lit("t3_idle2", 3'b000);
    req0 = 1'b1; req2 = 1'b1;
    cyc();              lit("t3_g0", 3'b001);
    req0 = 1'b0; req2 = 1'b0;
    pulse_finish();
    cyc();

    // Finish coincident with watchdog expiry.
    do_reset();
    req2 = 1'b1;
    cyc();
    repeat (15) cyc();
    req2 = 1'b0;
    pulse_finish();     lit("t5_rel", 3'b000);
    chk("t5_noerr", {31'd0, to_err}, 32'd0);
    chk("t5_tosel", {29'd0, to_sel}, 32'd0);
    cyc();

    // Asynchronous reset mid-grant.
    do_reset();
    req1 = 1'b1;
    cyc();              lit("t6_g1", 3'b010);
    cyc();
    #1 rst_n = 1'b0;
    #1;                 lit("t6_async", 3'b000);
    chk("t6_gnt", {29'd0, gnt2, gnt1, gnt0}, 32'd0);
    req1 = 1'b1; req2 = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();              lit("t6_first", 3'b010);
    req1 = 1'b0; req2 = 1'b0;
    pulse_finish();
    cyc();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      if ($urandom_range(0, 3) == 0) req2 = ~req2;
      finish = ($urandom_range(0, 11) == 0);
      cyc();
    end
    finish = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
